// File: rtl/shift_operand_fetcher.sv
// Fetches the dense-polynomial boundary words and the two accumulator words addressed
// by a pair of sparse shift positions, then hands off to the shift processor and latches its results.
//
// state     | meaning
// IDLE      | waiting for start; range-checks the shifts
// FETCH0    | read normal word 0 and accumulator word at high index
// FETCH1    | read normal word 551 and accumulator word at low index; capture first pair
// FETCH2    | read normal word 552; capture second pair
// CAPTURE   | capture normal word 552
// LAUNCH    | schedule the one-cycle start_process pulse and arm the timeout
// WAIT_PROC | wait for processing_done or timeout
// FINISH    | done pulse
module shift_operand_fetcher #(
  parameter int WORD_WIDTH = 32,
  parameter int N_WORDS    = 553,
  parameter int N_BITS     = 17669,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           high_shift,
  input  logic [15:0]           low_shift,
  output logic                  busy,
  output logic                  norm_rd_en,
  output logic [9:0]            norm_rd_addr,
  input  logic [WORD_WIDTH-1:0] norm_rd_data,
  output logic                  acc_rd_en,
  output logic [9:0]            acc_rd_addr,
  input  logic [WORD_WIDTH-1:0] acc_rd_data,
  output logic [WORD_WIDTH-1:0] normal_word_zero,
  output logic [WORD_WIDTH-1:0] normal_word_551,
  output logic [WORD_WIDTH-1:0] normal_word_552,
  output logic [WORD_WIDTH-1:0] acc_word_high,
  output logic [WORD_WIDTH-1:0] acc_word_low,
  output logic [15:0]           high_shift_o,
  output logic [15:0]           low_shift_o,
  output logic [9:0]            acc_start_idx_high,
  output logic [9:0]            acc_start_idx_low,
  output logic [4:0]            acc_shift_idx_high,
  output logic [4:0]            acc_shift_idx_low,
  output logic                  start_process,
  input  logic                  processing_done,
  input  logic [WORD_WIDTH-1:0] high_result_in,
  input  logic [WORD_WIDTH-1:0] low_result_in,
  output logic [WORD_WIDTH-1:0] high_result,
  output logic [WORD_WIDTH-1:0] low_result,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE, FETCH0, FETCH1, FETCH2, CAPTURE, LAUNCH, WAIT_PROC, FINISH
  } state_t;

  localparam int          CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [16:0] N_BITS_W  = 17'(N_BITS);
  localparam logic [9:0]  ADDR_LAST = 10'(N_WORDS - 1);
  localparam logic [9:0]  ADDR_PREV = 10'(N_WORDS - 2);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               range_err;
  logic               tmo_hit;

  assign range_err = ({1'b0, high_shift} >= N_BITS_W) || ({1'b0, low_shift} >= N_BITS_W);
  assign tmo_hit   = (tmo_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start && !range_err) state_nxt = FETCH0;
      FETCH0:    state_nxt = FETCH1;
      FETCH1:    state_nxt = FETCH2;
      FETCH2:    state_nxt = CAPTURE;
      CAPTURE:   state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_PROC;
      WAIT_PROC: begin
        if (processing_done) state_nxt = FINISH;
        else if (tmo_hit)    state_nxt = IDLE;
      end
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = (state == FINISH);
    norm_rd_en   = 1'b0;
    norm_rd_addr = '0;
    acc_rd_en    = 1'b0;
    acc_rd_addr  = '0;
    case (state)
      FETCH0: begin
        norm_rd_en  = 1'b1;
        acc_rd_en   = 1'b1;
        acc_rd_addr = acc_start_idx_high;
      end
      FETCH1: begin
        norm_rd_en   = 1'b1;
        norm_rd_addr = ADDR_PREV;
        acc_rd_en    = 1'b1;
        acc_rd_addr  = acc_start_idx_low;
      end
      FETCH2: begin
        norm_rd_en   = 1'b1;
        norm_rd_addr = ADDR_LAST;
      end
      default: ;
    endcase
  end

  // Datapath registers; memory data for a strobe issued in state S is captured on exit from S+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt            <= '0;
      error              <= 1'b0;
      start_process      <= 1'b0;
      high_shift_o       <= '0;
      low_shift_o        <= '0;
      acc_start_idx_high <= '0;
      acc_start_idx_low  <= '0;
      acc_shift_idx_high <= '0;
      acc_shift_idx_low  <= '0;
      normal_word_zero   <= '0;
      normal_word_551    <= '0;
      normal_word_552    <= '0;
      acc_word_high      <= '0;
      acc_word_low       <= '0;
      high_result        <= '0;
      low_result         <= '0;
    end else begin
      error         <= 1'b0;
      start_process <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (range_err) begin
              error <= 1'b1;
            end else begin
              high_shift_o       <= high_shift;
              low_shift_o        <= low_shift;
              acc_start_idx_high <= high_shift[14:5];
              acc_start_idx_low  <= low_shift[14:5];
              acc_shift_idx_high <= high_shift[4:0];
              acc_shift_idx_low  <= low_shift[4:0];
            end
          end
        end
        FETCH1: begin
          normal_word_zero <= norm_rd_data;
          acc_word_high    <= acc_rd_data;
        end
        FETCH2: begin
          normal_word_551 <= norm_rd_data;
          acc_word_low    <= acc_rd_data;
        end
        CAPTURE: normal_word_552 <= norm_rd_data;
        LAUNCH: begin
          start_process <= 1'b1;
          tmo_cnt       <= CNT_W'(TIMEOUT - 1);
        end
        WAIT_PROC: begin
          if (processing_done) begin
            high_result <= high_result_in;
            low_result  <= low_result_in;
          end else if (tmo_hit) begin
            error <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/shift_operand_fetcher.md
SHIFT_OPERAND_FETCHER -- requirements
Module: shift_operand_fetcher

Interface
REQ-001 SHALL have parameters: WORD_WIDTH, default 32, data word width; N_WORDS, default 553, dense-polynomial word count; N_BITS, default 17669, valid bit positions; TIMEOUT, default 64, max cycles waiting for processing_done.
REQ-002 SHALL have ports (name direction width meaning):
- clk input 1: single clock, rising edge.
- rst input 1: synchronous, active-high reset.
- start input 1: request pulse; high_shift and low_shift sampled with it.
- high_shift input 16: high sparse position.
- low_shift input 16: low sparse position.
- busy output 1: high while not IDLE.
- norm_rd_en output 1: normal-memory read strobe.
- norm_rd_addr output 10: normal-memory word address.
- norm_rd_data input WORD_WIDTH: normal-memory data, valid 1 cycle after a sampled strobe.
- acc_rd_en output 1: accumulator read strobe.
- acc_rd_addr output 10: accumulator word address.
- acc_rd_data input WORD_WIDTH: accumulator data, same 1-cycle latency.
- normal_word_zero, normal_word_551, normal_word_552 output WORD_WIDTH: captured words 0, 551, 552.
- acc_word_high, acc_word_low output WORD_WIDTH: captured accumulator words.
- high_shift_o, low_shift_o output 16: latched shifts.
- acc_start_idx_high, acc_start_idx_low output 10: shift / 32.
- acc_shift_idx_high, acc_shift_idx_low output 5: shift % 32.
- start_process output 1: one-cycle launch pulse to the shift processor.
- processing_done input 1: completion from the shift processor.
- high_result_in, low_result_in input WORD_WIDTH: shift-processor results.
- high_result, low_result output WORD_WIDTH: latched results.
- done output 1: one-cycle completion pulse.
- error output 1: one-cycle pulse on range error or timeout.

Function
REQ-003 SHALL implement states IDLE, FETCH0, FETCH1, FETCH2, CAPTURE, LAUNCH, WAIT_PROC, FINISH.
REQ-004 IDLE with start=1 SHALL latch both shifts and go to FETCH0; start outside IDLE SHALL be ignored.
REQ-005 If either shift >= N_BITS at start, SHALL pulse error next cycle, issue no reads, remain IDLE.
REQ-006 acc_start_idx SHALL equal shift[15:5] truncated to 10 bits; acc_shift_idx SHALL equal shift[4:0]; both registered with the latch.
REQ-007 FETCH0 SHALL drive norm_rd_en=1, norm_rd_addr=0, acc_rd_en=1, acc_rd_addr=acc_start_idx_high.
REQ-008 FETCH1 SHALL drive norm addr 551 and acc addr acc_start_idx_low, and capture norm_rd_data into normal_word_zero and acc_rd_data into acc_word_high.
REQ-009 FETCH2 SHALL drive norm addr 552 with acc_rd_en=0, and capture normal_word_551 and acc_word_low.
REQ-010 CAPTURE SHALL capture normal_word_552 with both strobes low.
REQ-011 LAUNCH SHALL assert start_process for exactly one cycle; start_process rises 5 cycles after the start-sampling edge.
REQ-012 WAIT_PROC SHALL latch high_result_in/low_result_in on the cycle processing_done=1 and go to FINISH.
REQ-013 FINISH SHALL pulse done for one cycle and return to IDLE; a new start is accepted the following cycle.
REQ-014 WAIT_PROC SHALL count cycles; after TIMEOUT cycles without processing_done it SHALL pulse error, leave results unchanged, and go to IDLE.
REQ-015 processing_done outside WAIT_PROC SHALL be ignored.
REQ-016 Captured operand outputs SHALL stay stable from capture until the next accepted start.
REQ-017 Read strobes SHALL be low in all states except FETCH0 to FETCH2 (norm) and FETCH0 to FETCH1 (acc).

Reset
REQ-018 rst=1 at any clock edge, including mid-fetch or WAIT_PROC, SHALL force IDLE and clear every output, counter and latched register to 0 on that edge.
REQ-019 start with rst=1 on the same edge SHALL be discarded.

Verification
REQ-020 high_shift=148, low_shift=342, memory returning addr+0x100 -> idx_high=4, shift_idx_high=20, idx_low=10, shift_idx_low=22; normal words 0x100/0x327/0x328; acc 0x104/0x10A; start_process 5 cycles after start.
REQ-021 processing_done 3 cycles after start_process with results 0x89CA8935/0x272A24D6 -> results latched, done pulses once.
REQ-022 high_shift=17669 -> error pulse, no read strobes, busy stays 0; high_shift=17668 -> accepted, idx 552, shift_idx 4.
REQ-023 processing_done withheld -> error after 64 WAIT_PROC cycles, return to IDLE, done never asserted.
REQ-024 rst during FETCH1 -> outputs 0 next cycle; start held high during busy -> no restart.
